// File: rtl/iob_ibex2axi_ot.sv
// Ibex LSU to AXI4 single-beat bridge with up to MAX_OUT outstanding
// transactions of one direction at a time, so responses return in order.
module iob_ibex2axi_ot #(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_VAL = 0,
  parameter int MAX_OUT    = 4
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic                    cke_i,

  input  logic                    ibex_req_i,
  input  logic                    ibex_we_i,
  input  logic [AXI_DATA_W/8-1:0] ibex_be_i,
  input  logic [AXI_ADDR_W-3:0]   ibex_addr_i,
  input  logic [AXI_DATA_W-1:0]   ibex_wdata_i,
  output logic                    ibex_gnt_o,
  output logic                    ibex_rvalid_o,
  output logic [AXI_DATA_W-1:0]   ibex_rdata_o,
  output logic                    ibex_err_o,

  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [AXI_ADDR_W-1:0]   awaddr_o,
  output logic [AXI_ID_W-1:0]     awid_o,
  output logic [AXI_LEN_W-1:0]    awlen_o,
  output logic [2:0]              awsize_o,
  output logic [1:0]              awburst_o,
  output logic                    awlock_o,
  output logic [3:0]              awcache_o,
  output logic [2:0]              awprot_o,
  output logic [3:0]              awqos_o,

  output logic                    wvalid_o,
  input  logic                    wready_i,
  output logic [AXI_DATA_W-1:0]   wdata_o,
  output logic [AXI_DATA_W/8-1:0] wstrb_o,
  output logic                    wlast_o,

  input  logic                    bvalid_i,
  output logic                    bready_o,
  input  logic [1:0]              bresp_i,
  input  logic [AXI_ID_W-1:0]     bid_i,

  output logic                    arvalid_o,
  input  logic                    arready_i,
  output logic [AXI_ADDR_W-1:0]   araddr_o,
  output logic [AXI_ID_W-1:0]     arid_o,
  output logic [AXI_LEN_W-1:0]    arlen_o,
  output logic [2:0]              arsize_o,
  output logic [1:0]              arburst_o,
  output logic                    arlock_o,
  output logic [3:0]              arcache_o,
  output logic [2:0]              arprot_o,
  output logic [3:0]              arqos_o,

  input  logic                    rvalid_i,
  output logic                    rready_o,
  input  logic [AXI_DATA_W-1:0]   rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic [AXI_ID_W-1:0]     rid_i,
  input  logic                    rlast_i
);

  localparam int                  CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0]    MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [AXI_ID_W-1:0] ID_VAL  = AXI_ID_W'(AXI_ID_VAL);
  localparam int                  BE_W    = AXI_DATA_W / 8;

  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q,  wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  // dir_q doubles as the captured write-enable: both load ibex_we_i on grant.
  logic                  dir_q,     dir_d;
  logic [AXI_ADDR_W-3:0] addr_q,    addr_d;
  logic [BE_W-1:0]       be_q,      be_d;
  logic [AXI_DATA_W-1:0] wdata_q,   wdata_d;

  logic slot_free, cnt_nz, dir_ok, gnt;
  logic r_acc, b_acc, rsp_acc, r_err, b_err;

  // Fixed single-beat, 32-bit, incrementing, unprotected transfers.
  assign awlen_o   = '0;
  assign arlen_o   = '0;
  assign awsize_o  = 3'd2;
  assign arsize_o  = 3'd2;
  assign awburst_o = 2'b01;
  assign arburst_o = 2'b01;
  assign awlock_o  = 1'b0;
  assign arlock_o  = 1'b0;
  assign awcache_o = '0;
  assign arcache_o = '0;
  assign awprot_o  = '0;
  assign arprot_o  = '0;
  assign awqos_o   = '0;
  assign arqos_o   = '0;
  assign awid_o    = ID_VAL;
  assign arid_o    = ID_VAL;
  assign wlast_o   = 1'b1;

  assign awvalid_o = awvalid_q;
  assign wvalid_o  = wvalid_q;
  assign arvalid_o = arvalid_q;
  assign awaddr_o  = {addr_q, 2'b00};
  assign araddr_o  = {addr_q, 2'b00};
  assign wdata_o   = wdata_q;
  assign wstrb_o   = be_q;

  // A new request waits for the previous address/data phase to drain, and a
  // direction change waits for every outstanding response to come back.
  assign slot_free  = ~awvalid_q & ~wvalid_q & ~arvalid_q;
  assign cnt_nz     = (cnt_q != '0);
  assign dir_ok     = ~cnt_nz | (ibex_we_i == dir_q);
  assign gnt        = ibex_req_i & cke_i & slot_free & (cnt_q < MAX_CNT) & dir_ok;
  assign ibex_gnt_o = gnt;

  assign rready_o = cke_i & cnt_nz & ~dir_q;
  assign bready_o = cke_i & cnt_nz &  dir_q;
  assign r_acc    = rvalid_i & rready_o;
  assign b_acc    = bvalid_i & bready_o;
  assign rsp_acc  = r_acc | b_acc;

  assign r_err = (rresp_i != 2'b00) | (rid_i != ID_VAL) | ~rlast_i;
  assign b_err = (bresp_i != 2'b00) | (bid_i != ID_VAL);

  assign ibex_rvalid_o = rsp_acc;
  assign ibex_err_o    = (r_acc & r_err) | (b_acc & b_err);
  assign ibex_rdata_o  = r_acc ? rdata_i : '0;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    dir_d     = dir_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;

    if (gnt) begin
      addr_d    = ibex_addr_i;
      be_d      = ibex_be_i;
      wdata_d   = ibex_wdata_i;
      dir_d     = ibex_we_i;
      awvalid_d = ibex_we_i;
      wvalid_d  = ibex_we_i;
      arvalid_d = ~ibex_we_i;
    end else begin
      // Grant only happens with all valids low, so handshakes never race it.
      if (awready_i) awvalid_d = 1'b0;
      if (wready_i)  wvalid_d  = 1'b0;
      if (arready_i) arvalid_d = 1'b0;
    end

    case ({gnt, rsp_acc})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: the holding registers are reset along with the control state so a
  // reset leaves awaddr/wdata/wstrb at a known zero rather than stale data.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else if (cke_i) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule
